// File: rtl/lenet_pkg.sv
// Shared LeNet constants and types: default map geometry, lane type and pooling FSM states.
package lenet_pkg;

  localparam int unsigned LenetDw  = 16;
  localparam int unsigned LenetCh  = 6;
  localparam int unsigned LenetFmW = 28;
  localparam int unsigned LenetFmH = 28;

  typedef logic signed [LenetDw-1:0] lane_t;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StOut
  } pool_state_e;

endpackage

// File: rtl/pool_lane_max.sv
// One pooling lane: loads the incoming value or keeps the signed running maximum.
module pool_lane_max
  import lenet_pkg::*;
#(
  parameter int unsigned DW = LenetDw
) (
  input  logic signed [DW-1:0] acc,
  input  logic signed [DW-1:0] din,
  input  logic                 load,
  output logic signed [DW-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    if (load || (din > acc)) begin
      acc_next = din;
    end
  end

endmodule

// File: rtl/pool_sram_reader.sv
// Reads a conv1 feature map from SRAM and streams 2x2 stride-2 max-pooled words.
// Optional POOL_RELU_EN clamps negative pooled lanes to zero before output.
module pool_sram_reader
  import lenet_pkg::*;
#(
  parameter int unsigned WIDTH  = 96,
  parameter int unsigned W_ADDR = 10,
  parameter int unsigned CH     = LenetCh,
  parameter int unsigned DW     = LenetDw,
  parameter int unsigned FM_W   = LenetFmW,
  parameter int unsigned FM_H   = LenetFmH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [W_ADDR-1:0] read_aa,
  output logic              read_cen,
  input  logic [WIDTH-1:0]  read_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last
);

  localparam int unsigned OutW = FM_W / 2;
  localparam int unsigned OutH = FM_H / 2;

  if (CH * DW != WIDTH) begin : g_chk_width
    $error("pool_sram_reader: WIDTH must equal CH*DW");
  end
  if ((FM_W % 2 != 0) || (FM_H % 2 != 0)) begin : g_chk_even
    $error("pool_sram_reader: FM_W and FM_H must be even");
  end
  if ((64'd1 << W_ADDR) < (64'(FM_W) * 64'(FM_H))) begin : g_chk_addr
    $error("pool_sram_reader: W_ADDR too narrow for the feature map");
  end

  pool_state_e       state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [W_ADDR-1:0] row_q, row_d, col_q, col_d;
  logic [W_ADDR-1:0] row_base_q, row_base_d, col_off_q, col_off_d;
  logic [W_ADDR-1:0] k_off;
  logic [WIDTH-1:0]  acc_q, acc_d, out_data_q, out_data_d;
  logic [WIDTH-1:0]  acc_next, pooled;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic              done_q, done_d;
  logic              is_last, capture, load;

  assign is_last = (row_q == W_ADDR'(OutH - 1)) && (col_q == W_ADDR'(OutW - 1));
  // Data for read k arrives one cycle later: k-1 in READ, k=3 in DRAIN.
  assign capture = ((state_q == StRead) && (k_q != 2'd0)) || (state_q == StDrain);
  assign load    = (state_q == StRead) && (k_q == 2'd1);

  always_comb begin
    k_off = '0;
    unique case (k_q)
      2'd0: k_off = '0;
      2'd1: k_off = W_ADDR'(1);
      2'd2: k_off = W_ADDR'(FM_W);
      2'd3: k_off = W_ADDR'(FM_W + 1);
      default: k_off = '0;
    endcase
  end

  assign read_aa  = row_base_q + col_off_q + k_off;
  assign read_cen = (state_q != StRead);

  for (genvar i = 0; i < CH; i++) begin : g_lane
    logic signed [DW-1:0] lane_next;

    pool_lane_max #(
      .DW(DW)
    ) u_lane_max (
      .acc      (acc_q[i*DW +: DW]),
      .din      (read_out[i*DW +: DW]),
      .load     (load),
      .acc_next (lane_next)
    );

    assign acc_next[i*DW +: DW] = lane_next;
`ifdef POOL_RELU_EN
    assign pooled[i*DW +: DW] = lane_next[DW-1] ? '0 : lane_next;
`else
    assign pooled[i*DW +: DW] = lane_next;
`endif
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    row_d       = row_q;
    col_d       = col_q;
    row_base_d  = row_base_q;
    col_off_d   = col_off_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    if (capture) begin
      acc_d = acc_next;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRead;
          k_d        = 2'd0;
          row_d      = '0;
          col_d      = '0;
          row_base_d = '0;
          col_off_d  = '0;
        end
      end
      StRead: begin
        if (k_q == 2'd3) begin
          state_d = StDrain;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      StDrain: begin
        out_data_d  = pooled;
        out_valid_d = 1'b1;
        out_last_d  = is_last;
        state_d     = StOut;
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (is_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StRead;
            k_d     = 2'd0;
            if (col_q == W_ADDR'(OutW - 1)) begin
              col_d      = '0;
              col_off_d  = '0;
              row_d      = row_q + W_ADDR'(1);
              row_base_d = row_base_q + W_ADDR'(2 * FM_W);
            end else begin
              col_d     = col_q + W_ADDR'(1);
              col_off_d = col_off_q + W_ADDR'(2);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= 2'd0;
      row_q       <= '0;
      col_q       <= '0;
      row_base_q  <= '0;
      col_off_q   <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      row_q       <= row_d;
      col_q       <= col_d;
      row_base_q  <= row_base_d;
      col_off_q   <= col_off_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_pool_sram_reader.sv
// Bench for pool_sram_reader: a 4x4 and a default 28x28 instance against a pooling reference model.
module tb_pool_sram_reader;
  import lenet_pkg::*;

  localparam int unsigned Ch    = 6;
  localparam int unsigned Dw    = 16;
  localparam int unsigned Width = 96;
  localparam int unsigned SW    = 4;
  localparam int unsigned SH    = 4;
  localparam int unsigned LW    = 28;
  localparam int unsigned LH    = 28;
  localparam int unsigned MaxA  = LW * LH;
  localparam int unsigned MaxP  = (LW / 2) * (LH / 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0 is the 4x4 instance, index 1 the default 28x28 instance.
  logic [1:0]             start = '0;
  logic [1:0]             ready = '0;
  logic [1:0]             busy, done, cen, valid, last;
  logic [1:0][Width-1:0]  rd, data;
  logic [1:0][9:0]        aa;
  logic [3:0]             aa_s;
  logic [1:0]             rdy_rand = '0;
  logic [1:0]             rdy_force = '0;

  assign aa[0] = {6'd0, aa_s};

  pool_sram_reader #(
    .WIDTH(Width), .W_ADDR(4), .CH(Ch), .DW(Dw), .FM_W(SW), .FM_H(SH)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .read_aa(aa_s), .read_cen(cen[0]), .read_out(rd[0]), .out_valid(valid[0]),
    .out_ready(ready[0]), .out_data(data[0]), .out_last(last[0])
  );

  pool_sram_reader dut_l (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .read_aa(aa[1]), .read_cen(cen[1]), .read_out(rd[1]), .out_valid(valid[1]),
    .out_ready(ready[1]), .out_data(data[1]), .out_last(last[1])
  );

  logic [Width-1:0] mem [2][MaxA];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!cen[d]) rd[d] <= mem[d][aa[d]];
    end
  end

  always @(posedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      ready[d] = rdy_rand[d] ? ($urandom_range(0, 3) != 0) : rdy_force[d];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [Width-1:0] got,
                       input logic [Width-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: per-lane signed max over the 2x2 window, straight from the map contents.
  function automatic logic [Width-1:0] ref_word(input int d, input int r, input int c);
    int fw;
    int best;
    int a;
    lane_t v;
    logic [Width-1:0] res;
    fw  = d ? LW : SW;
    res = '0;
    for (int i = 0; i < Ch; i++) begin
      best = -(1 << 20);
      for (int q = 0; q < 4; q++) begin
        a = (2 * r + q / 2) * fw + 2 * c + q % 2;
        v = mem[d][a][i*Dw +: Dw];
        if (v > best) best = v;
      end
`ifdef POOL_RELU_EN
      if (best < 0) best = 0;
`endif
      res[i*Dw +: Dw] = best[Dw-1:0];
    end
    return res;
  endfunction

  int               exp_addr [2][4*MaxP];
  logic [Width-1:0] exp_word [2][MaxP];
  int               n_addr[2], n_pix[2], rd_ptr[2], hs_cnt[2], done_cnt[2];
  int               start_cyc[2], last_hs_cyc[2];
  bit               seen_valid[2], after_hs[2], prev_wait[2];
  logic [Width-1:0] prev_data[2], first_word[2], last_word[2];

  task automatic mon(input int d);
    string n;
    n = d ? "l" : "s";
    if (!cen[d]) begin
      check({n, "_read_in_pass"}, rd_ptr[d] < n_addr[d], 1);
      if (rd_ptr[d] < n_addr[d]) begin
        check({n, "_read_addr"}, aa[d], exp_addr[d][rd_ptr[d]]);
        rd_ptr[d]++;
      end
    end
    if (valid[d]) check({n, "_no_read_in_out"}, cen[d], 1);
    if (after_hs[d]) begin
      check({n, "_read_after_hs"}, cen[d], 0);
      after_hs[d] = 0;
    end
    if (prev_wait[d]) begin
      check({n, "_hold_valid"}, valid[d], 1);
      check({n, "_hold_data"}, data[d], prev_data[d]);
    end
    if (valid[d] && !seen_valid[d]) begin
      seen_valid[d] = 1;
      check({n, "_first_latency"}, cyc - start_cyc[d], 6);
    end
    if (valid[d] && ready[d]) begin
      check({n, "_hs_in_pass"}, hs_cnt[d] < n_pix[d], 1);
      if (hs_cnt[d] < n_pix[d]) begin
        check({n, "_data"}, data[d], exp_word[d][hs_cnt[d]]);
        check({n, "_last"}, last[d], hs_cnt[d] == n_pix[d] - 1);
        if (hs_cnt[d] == 0) first_word[d] = data[d];
        last_word[d] = data[d];
      end
      after_hs[d]    = (hs_cnt[d] < n_pix[d] - 1);
      last_hs_cyc[d] = cyc;
      hs_cnt[d]++;
    end
    prev_wait[d] = valid[d] && !ready[d];
    prev_data[d] = data[d];
    if (done[d]) begin
      done_cnt[d]++;
      check({n, "_done_latency"}, cyc - last_hs_cyc[d], 1);
      check({n, "_busy_at_done"}, busy[d], 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) mon(d);
    end
  end

  task automatic start_pass(input int d);
    int fw, fh, a, p, b;
    fw = d ? LW : SW;
    fh = d ? LH : SH;
    a  = 0;
    p  = 0;
    for (int r = 0; r < fh / 2; r++) begin
      for (int c = 0; c < fw / 2; c++) begin
        b = 2 * r * fw + 2 * c;
        exp_addr[d][a]   = b;
        exp_addr[d][a+1] = b + 1;
        exp_addr[d][a+2] = b + fw;
        exp_addr[d][a+3] = b + fw + 1;
        a += 4;
        exp_word[d][p] = ref_word(d, r, c);
        p++;
      end
    end
    n_addr[d]     = a;
    n_pix[d]      = p;
    rd_ptr[d]     = 0;
    hs_cnt[d]     = 0;
    seen_valid[d] = 0;
    after_hs[d]   = 0;
    prev_wait[d]  = 0;
    @(posedge clk);
    #1 start[d] = 1'b1;
    start_cyc[d] = cyc;
    @(posedge clk);
    #1 start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    int c0, k;
    string n;
    n  = d ? "l" : "s";
    c0 = done_cnt[d];
    k  = 0;
    while (done_cnt[d] == c0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({n, "_done_seen"}, done_cnt[d] != c0, 1);
    repeat (5) @(posedge clk);
    check({n, "_handshakes"}, hs_cnt[d], n_pix[d]);
    check({n, "_reads"}, rd_ptr[d], n_addr[d]);
    check({n, "_one_done"}, done_cnt[d], c0 + 1);
    check({n, "_idle_after"}, busy[d], 0);
  endtask

  initial begin
    int k;
    logic [Dw-1:0] neg_exp;
    for (int a = 0; a < 16; a++) begin
      for (int i = 0; i < Ch; i++) mem[0][a][i*Dw +: Dw] = Dw'(a);
    end
    for (int a = 0; a < int'(MaxA); a++) mem[1][a] = {$urandom, $urandom, $urandom};
    for (int d = 0; d < 2; d++) begin
      done_cnt[d]  = 0;
      n_addr[d]    = 0;
      n_pix[d]     = 0;
      rd_ptr[d]    = 0;
      hs_cnt[d]    = 0;
      seen_valid[d] = 1;
      after_hs[d]  = 0;
      prev_wait[d] = 0;
      last_hs_cyc[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_cen", cen[d], 1);
      check("reset_aa", aa[d], 0);
      check("reset_valid", valid[d], 0);
      check("reset_data", data[d], 0);
      check("reset_last", last[d], 0);
      check("reset_busy", busy[d], 0);
      check("reset_done", done[d], 0);
    end

    // Abort a pass with reset while reads are in flight.
    rdy_force[0] = 1'b1;
    start_pass(0);
    @(posedge clk);
    #1 check("s_in_read", cen[0], 0);
    rst_n = 1'b0;
    #1;
    check("abort_cen", cen[0], 1);
    check("abort_valid", valid[0], 0);
    check("abort_busy", busy[0], 0);
    @(negedge clk);
    check("abort_cen_next", cen[0], 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Address ramp: lanes of word a equal a.
    start_pass(0);
    wait_done(0, 200);
    check("s_ramp_first", first_word[0][Dw-1:0], 5);
    check("s_ramp_last", last_word[0][Dw-1:0], 15);

    // Negative lanes with the first pixel held off for 10 cycles.
    mem[0][0][Dw-1:0] = -16'sd3;
    mem[0][1][Dw-1:0] = -16'sd1;
    mem[0][4][Dw-1:0] = -16'sd7;
    mem[0][5][Dw-1:0] = -16'sd2;
    @(posedge clk);
    #1 rdy_force[0] = 1'b0;
    start_pass(0);
    k = 0;
    while (!valid[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("s_valid_rise", valid[0], 1);
    repeat (10) @(posedge clk);
    check("s_no_hs_while_held", hs_cnt[0], 0);
    #1 rdy_force[0] = 1'b1;
    wait_done(0, 200);
`ifdef POOL_RELU_EN
    neg_exp = '0;
`else
    neg_exp = 16'hffff;
`endif
    check("s_neg_lane0", first_word[0][Dw-1:0], neg_exp);

    // Random data, random backpressure, stray start while busy.
    for (int a = 0; a < 16; a++) mem[0][a] = {$urandom, $urandom, $urandom};
    rdy_rand[0] = 1'b1;
    start_pass(0);
    repeat (10) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    wait_done(0, 400);

    // Full 28x28 map.
    rdy_rand[1] = 1'b1;
    start_pass(1);
    repeat (50) @(posedge clk);
    #1 start[1] = 1'b1;
    @(posedge clk);
    #1 start[1] = 1'b0;
    wait_done(1, 8000);
    check("l_first_read", exp_addr[1][0], 0);
    check("l_last_read", exp_addr[1][4*MaxP-1], 783);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
